// File: rtl/arith_pkg.sv
// Shared widths and FSM encoding for the divider / recombiner pair.
package arith_pkg;
  localparam int Q_W   = 16;
  localparam int B_W   = 8;
  localparam int P_W   = Q_W + B_W;
  localparam int CNT_W = $clog2(B_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mul_add_step.sv
// One shift-add step: conditionally folds the shifted multiplicand into the accumulator.
module mul_add_step
  import arith_pkg::*;
(
  input  logic [P_W-1:0] acc,
  input  logic [P_W-1:0] mcand,
  input  logic           mplier_lsb,
  output logic [P_W-1:0] acc_next
);
  assign acc_next = acc + (mplier_lsb ? mcand : '0);
endmodule

// File: rtl/mul_add_16bit_seq.sv
// Sequential recombiner: product = q*b + r, one multiplier bit per cycle.
// state | meaning
// IDLE  | waiting for start
// RUN   | B_W shift-add cycles, busy high
// DONE  | single-cycle done pulse; start here is accepted back-to-back
module mul_add_16bit_seq
  import arith_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [Q_W-1:0] q_in,
  input  logic [B_W-1:0] b_in,
  input  logic [Q_W-1:0] r_in,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] product
);
  state_t           state;
  logic [P_W-1:0]   acc;
  logic [P_W-1:0]   mcand;
  logic [B_W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   acc_next;

  mul_add_step u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier_lsb (mplier[0]),
    .acc_next   (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc    <= {{B_W{1'b0}}, r_in};
            mcand  <= {{B_W{1'b0}}, q_in};
            mplier <= b_in;
            cnt    <= '0;
            state  <= RUN;
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // the last step's sum goes straight to the output register
          if (cnt == CNT_W'(B_W - 1)) begin
            product <= acc_next;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_add_16bit_seq.sv
// Self-checking bench for mul_add_16bit_seq: behavioural timing/value model plus directed literals.
module tb_mul_add_16bit_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] q_in = '0;
  logic [7:0]  b_in = '0;
  logic [15:0] r_in = '0;
  logic        busy;
  logic        done;
  logic [23:0] product;

  int checks = 0;
  int errors = 0;

  mul_add_16bit_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .q_in    (q_in),
    .b_in    (b_in),
    .r_in    (r_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted op finishes 8 edges later; start only counts when nothing is in flight.
  int          m_rem = 0;
  logic [23:0] m_pend = '0;
  logic [23:0] m_prod = '0;
  logic        m_done = 1'b0;
  logic        m_valid = 1'b0;
  int          done_count = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_prod = '0; m_done = 1'b0; m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_prod = m_pend;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_pend = 24'(q_in) * 24'(b_in) + 24'(r_in);
        m_rem  = 8;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_rem > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("product", 32'(product), 32'(m_prod));
      if (busy && done) chk("busy_done_overlap", 32'd1, 32'd0);
      if (done) done_count++;
    end
  end

  // Issue one op from idle; returns product at done and cycles from accepting edge.
  task automatic run_op(input logic [15:0] q, input logic [7:0] b, input logic [15:0] r,
                        output logic [23:0] prod, output int lat);
    bit seen;
    @(negedge clk);
    q_in = q; b_in = b; r_in = r; start = 1'b1;
    @(posedge clk);
    lat = 0; seen = 0; prod = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        q_in = 16'($urandom); b_in = 8'($urandom); r_in = 16'($urandom);
      end
      if (done) begin seen = 1; prod = product; end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output logic [23:0] prod, output int lat);
    bit seen;
    lat = 0; seen = 0; prod = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin seen = 1; prod = product; end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [23:0] p;
    int          lat;
    int          busy_cycles;
    int          dc;
    logic [15:0] a;
    logic [7:0]  b;

    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 8'h56, 16'h0012, p, lat);
    chk("t1_product", 32'(p), 32'h061D8A);
    chk("t1_latency", 32'(lat), 32'd9);

    // busy duration
    @(negedge clk);
    q_in = 16'h0001; b_in = 8'h01; r_in = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", 32'(busy_cycles), 32'd8);

    run_op(16'hFFFF, 8'hFF, 16'hFFFF, p, lat);
    chk("t2_product_max", 32'(p), 32'hFFFF00);

    run_op(16'hABCD, 8'h00, 16'h0042, p, lat);
    chk("t3_product_b0", 32'(p), 32'h000042);
    chk("t3_latency", 32'(lat), 32'd9);

    run_op(16'd142, 8'd7, 16'd6, p, lat);
    chk("t4_roundtrip_1000", 32'(p), 32'h0003E8);

    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      run_op(a / 16'(b), b, a % 16'(b), p, lat);
      chk("t4_roundtrip_rand", 32'(p), 32'(a));
    end

    // mid-RUN restart ignored; start held through DONE accepted back-to-back
    @(negedge clk);
    q_in = 16'h0102; b_in = 8'h03; r_in = 16'h0004; start = 1'b1;
    @(negedge clk);
    q_in = 16'h7777; b_in = 8'h99; r_in = 16'h1111; start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    q_in = 16'h0005; b_in = 8'h06; r_in = 16'h0007;
    wait_done(p, lat);
    chk("t5_first_result", 32'(p), 32'h00030A);
    @(negedge clk);
    start = 1'b0;
    q_in = 16'hFFFF; b_in = 8'hFF; r_in = 16'hFFFF;
    wait_done(p, lat);
    chk("t5_b2b_result", 32'(p), 32'h000025);
    chk("t5_b2b_latency", 32'(lat + 1), 32'd9);

    // reset during RUN discards the op
    @(negedge clk);
    q_in = 16'h4321; b_in = 8'h21; r_in = 16'h0009; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_product", 32'(product), 32'd0);
    rst = 1'b0;
    dc = done_count;
    repeat (15) @(negedge clk);
    chk("t6_no_done_after_rst", 32'(done_count - dc), 32'd0);
    run_op(16'h0010, 8'h10, 16'h0001, p, lat);
    chk("t6_after_rst_product", 32'(p), 32'h000101);
    chk("t6_after_rst_latency", 32'(lat), 32'd9);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
